// File: rtl/rle_row_codec_if.sv
// rle_row_codec_if: pixel FIFO, row control and packet byte stream of rle_row_codec
interface rle_row_codec_if;
  logic [15:0] i_pixel;
  logic        i_empty;
  logic        o_fetch;
  logic        i_frame_start;
  logic        i_delta_en;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_row_done;
  logic        o_busy;
  modport slave (
    input  i_pixel, i_empty, i_frame_start, i_delta_en, i_byte_ready,
    output o_fetch, o_byte, o_byte_valid, o_row_done, o_busy
  );
  modport master (
    output i_pixel, i_empty, i_frame_start, i_delta_en, i_byte_ready,
    input  o_fetch, o_byte, o_byte_valid, o_row_done, o_busy
  );
endinterface

// File: rtl/rle_row_codec.sv
// rle_row_codec: YUV422 row run-length encoder with previous-row delta suppression and 5-byte packets
module rle_row_codec #(
  parameter int RowPixelWidth = 640,
  parameter int RunLimit = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  rle_row_codec_if.slave bus
);
  localparam int AW = $clog2(RowPixelWidth);
  localparam int EW = AW + 1;
  localparam logic [AW-1:0] P_LAST = AW'(RowPixelWidth - 1);
  localparam logic [AW-1:0] P_HALF = AW'(RowPixelWidth / 2);
  localparam logic [EW-1:0] E_U = EW'(RowPixelWidth);
  localparam logic [EW-1:0] E_V = EW'(RowPixelWidth + RowPixelWidth / 2);
  localparam logic [EW-1:0] E_YL = EW'(RowPixelWidth - 1);
  localparam logic [EW-1:0] E_UL = EW'(RowPixelWidth + RowPixelWidth / 2 - 1);
  localparam logic [EW-1:0] E_LAST = EW'(2 * RowPixelWidth - 1);
  localparam logic [8:0] R_LIM = 9'(RunLimit);

  typedef enum logic [1:0] {LOAD, SCAN, EMIT, DONE} state_t;
  state_t r_state, w_next;

  logic [7:0] r_y [2][RowPixelWidth];
  logic [7:0] r_c [2][RowPixelWidth];
  logic [AW-1:0] r_p;
  logic r_bank, r_pvalid, r_delta, r_pend, r_rc;
  logic [7:0] r_row, r_cur, r_prv, r_rv, r_pv, r_pl;
  logic [EW-1:0] r_e;
  logic [1:0] r_ph, r_pch;
  logic [11:0] r_rs, r_ps;
  logic [8:0] r_rl;
  logic [2:0] r_bi;

  logic w_fetch, w_chg, w_close, w_ext, w_last, w_eold, w_enew;
  logic w_proc, w_flush, w_emit, w_xfer, w_pkt_end, w_fin;
  logic [AW-1:0] w_wc, w_ra;
  logic [1:0] w_ch;
  logic [EW-1:0] w_base;
  logic [11:0] w_idx, w_ns;
  logic [8:0] w_nl;

  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_y[r_bank][r_p] <= bus.i_pixel[15:8];
      r_c[r_bank][w_wc] <= bus.i_pixel[7:0];
    end
    r_cur <= w_ch == 2'd0 ? r_y[r_bank][w_ra] : r_c[r_bank][w_ra];
    r_prv <= w_ch == 2'd0 ? r_y[~r_bank][w_ra] : r_c[~r_bank][w_ra];
  end

  always_comb begin
    w_fetch = r_state == LOAD && !bus.i_empty;
    w_wc = (r_p >> 1) + (r_p[0] ? P_HALF : '0);
    w_ch = r_e < E_U ? 2'd0 : r_e < E_V ? 2'd1 : 2'd2;
    w_base = w_ch == 2'd0 ? '0 : w_ch == 2'd1 ? E_U : E_V;
    w_ra = AW'(w_ch == 2'd0 ? r_e : r_e - E_U);
    w_idx = 12'(r_e - w_base);
    w_chg = !r_pvalid || !r_delta || r_cur != r_prv;
    w_close = r_rl != 9'd0 && (r_cur != r_rv || w_chg != r_rc || r_rl == R_LIM);
    w_ext = r_rl != 9'd0 && !w_close;
    w_ns = w_ext ? r_rs : w_idx;
    w_nl = w_ext ? r_rl + 9'd1 : 9'd1;
    w_last = r_e == E_YL || r_e == E_UL || r_e == E_LAST;
    w_eold = w_close && r_rc;
    w_enew = !w_eold && w_last && w_chg;
    w_proc = r_state == SCAN && r_ph == 2'd1;
    w_flush = r_state == SCAN && r_ph == 2'd2;
    w_emit = (w_proc && (w_eold || w_enew)) || (w_flush && r_rc);
    w_xfer = r_state == EMIT && bus.i_byte_ready;
    w_pkt_end = w_xfer && r_bi == 3'd4;
    w_fin = (w_proc && !(w_eold || w_enew)) || (w_flush && !r_rc) || (w_pkt_end && !r_pend);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD: w_next = w_fetch && r_p == P_LAST ? SCAN : LOAD;
      SCAN: w_next = w_emit ? EMIT : w_fin && r_e == E_LAST ? DONE : SCAN;
      EMIT: w_next = !w_pkt_end ? EMIT : w_fin && r_e == E_LAST ? DONE : SCAN;
      default: w_next = LOAD;
    endcase
  end

  always_comb begin
    bus.o_fetch = w_fetch;
    bus.o_byte_valid = r_state == EMIT;
    bus.o_row_done = r_state == DONE;
    bus.o_busy = r_state != LOAD;
    bus.o_byte = r_state != EMIT ? 8'h00 : r_bi == 3'd0 ? r_ps[7:0] : r_bi == 3'd1 ? r_row :
                 r_bi == 3'd2 ? r_pv : r_bi == 3'd3 ? r_pl : {r_pch, 2'b00, r_ps[11:8]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
      r_bank <= 1'b0;
      r_pvalid <= 1'b0;
      r_delta <= 1'b0;
      r_pend <= 1'b0;
      r_row <= '0;
      r_e <= '0;
      r_ph <= '0;
      r_rv <= '0;
      r_rc <= 1'b0;
      r_rs <= '0;
      r_rl <= '0;
      r_ps <= '0;
      r_pv <= '0;
      r_pl <= '0;
      r_pch <= '0;
      r_bi <= '0;
    end else begin
      if (w_fetch) r_p <= r_p == P_LAST ? '0 : r_p + 1'b1;
      if (r_state == LOAD && r_p == '0 && bus.i_frame_start) begin
        r_row <= '0;
        r_pvalid <= 1'b0;
      end
      if (w_fetch && r_p == P_LAST) begin
        r_e <= '0;
        r_ph <= '0;
        r_rl <= '0;
        r_delta <= bus.i_delta_en;
      end
      if (r_state == SCAN && r_ph == 2'd0) r_ph <= 2'd1;
      if (w_proc) begin
        r_rv <= r_cur;
        r_rc <= w_chg;
        r_rs <= w_ns;
        r_rl <= w_last && !w_eold ? 9'd0 : w_nl;
        r_pend <= w_eold && w_last;
        r_pv <= w_eold ? r_rv : r_cur;
        r_ps <= w_eold ? r_rs : w_ns;
        r_pl <= w_eold ? 8'(r_rl - 9'd1) : 8'(w_nl - 9'd1);
        r_pch <= w_ch;
      end
      if (w_flush) begin
        r_rl <= '0;
        r_pend <= 1'b0;
        r_pv <= r_rv;
        r_ps <= r_rs;
        r_pl <= 8'(r_rl - 9'd1);
        r_pch <= w_ch;
      end
      if (w_xfer) r_bi <= w_pkt_end ? '0 : r_bi + 3'd1;
      if (w_pkt_end && r_pend) r_ph <= 2'd2;
      if (w_fin) begin
        r_ph <= 2'd0;
        r_e <= r_e + 1'b1;
      end
      if (r_state == DONE) begin
        r_row <= r_row + 8'd1;
        r_bank <= ~r_bank;
        r_pvalid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rle_row_codec.sv
// tb_rle_row_codec: directed rows against a byte scoreboard for rle_row_codec (8 pixels, run limit 4)
module tb_rle_row_codec;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  int n_xfer = 0;
  int cyc = 0;
  int last_xfer = 0;
  int base;
  logic [7:0] exp_q [$];

  rle_row_codec_if bus();

  rle_row_codec #(.RowPixelWidth(8), .RunLimit(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && bus.o_byte_valid === 1'b1 && bus.i_byte_ready === 1'b1) begin
      n_xfer++;
      last_xfer = cyc;
      if (exp_q.size() > 0) chk("byte", bus.o_byte, exp_q.pop_front());
      else begin
        total++;
        bad++;
        $error("FAIL extra_byte: got %0h, want none", bus.o_byte);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] b0, b1, b2, b3, b4);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
  endtask

  task automatic push_row(input logic [7:0] row);
    push_pkt(8'h00, row, 8'h10, 8'h03, 8'h00);
    push_pkt(8'h04, row, 8'h10, 8'h03, 8'h00);
    push_pkt(8'h00, row, 8'h80, 8'h03, 8'h40);
    push_pkt(8'h00, row, 8'h80, 8'h03, 8'h80);
  endtask

  task automatic feed(input logic [7:0] y5, input bit gaps, input bit fs);
    for (int k = 0; k < 1000 && bus.o_busy === 1'b1; k++) tick;
    chk("load_ready", bus.o_busy, 0);
    for (int p = 0; p < 8; p++) begin
      if (gaps) begin
        bus.i_empty = 1'b1;
        bus.i_frame_start = 1'b0;
        @(negedge clk);
        chk("fetch_gap", bus.o_fetch, 0);
        tick;
      end
      bus.i_empty = 1'b0;
      bus.i_pixel = p == 5 ? {y5, 8'h80} : 16'h1080;
      bus.i_frame_start = fs && p == 0;
      @(negedge clk);
      chk("fetch", bus.o_fetch, 1);
      tick;
    end
    bus.i_empty = 1'b1;
    bus.i_frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit lat_chk);
    bit seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = bus.o_row_done === 1'b1;
    end
    chk({tag, "_done"}, seen, 1);
    if (lat_chk) chk({tag, "_lat"}, cyc - last_xfer, 1);
    chk({tag, "_left"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.o_row_done, 0);
    tick;
  endtask

  task automatic wait_xfer(input string tag, input int target);
    for (int k = 0; k < 500 && n_xfer < target; k++) tick;
    chk(tag, n_xfer, target);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_pixel = '0;
    bus.i_empty = 1'b1;
    bus.i_frame_start = 1'b0;
    bus.i_delta_en = 1'b0;
    bus.i_byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch", bus.o_fetch, 0);
    chk("rst_valid", bus.o_byte_valid, 0);
    chk("rst_byte", bus.o_byte, 0);
    chk("rst_done", bus.o_row_done, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    tick;

    push_row(8'h00);
    feed(8'h10, 1'b0, 1'b1);
    wait_done("full", 1'b1);

    bus.i_delta_en = 1'b1;
    feed(8'h10, 1'b0, 1'b0);
    wait_done("same", 1'b0);

    bus.i_delta_en = 1'b0;
    push_row(8'h02);
    base = n_xfer;
    feed(8'h10, 1'b0, 1'b0);
    wait_xfer("stall_reach", base + 1);
    bus.i_byte_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.o_byte_valid, 1);
      chk("stall_byte", bus.o_byte, 8'h02);
      tick;
    end
    bus.i_byte_ready = 1'b1;
    wait_done("stall", 1'b1);
    chk("stall_count", n_xfer - base, 20);

    push_row(8'h00);
    feed(8'h10, 1'b1, 1'b1);
    wait_done("gaps", 1'b1);

    bus.i_delta_en = 1'b1;
    push_pkt(8'h05, 8'h01, 8'h20, 8'h00, 8'h00);
    feed(8'h20, 1'b0, 1'b0);
    wait_done("delta", 1'b0);

    bus.i_delta_en = 1'b0;
    push_row(8'h02);
    base = n_xfer;
    feed(8'h10, 1'b0, 1'b0);
    wait_xfer("rst_reach", base + 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.o_byte_valid, 0);
    chk("arst_byte", bus.o_byte, 0);
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_done", bus.o_row_done, 0);
    exp_q.delete();
    @(negedge clk);
    chk("arst_hold", bus.o_byte_valid, 0);
    tick;
    rst_n = 1'b1;
    tick;

    bus.i_delta_en = 1'b1;
    push_row(8'h00);
    feed(8'h10, 1'b0, 1'b0);
    wait_done("post_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rle_row_codec.md
# rle_row_codec

Parametrised run-length compressor for YUV422 video rows, the next generation of the row compressor that feeds the UART link. It pulls one row of pixels from the capture FIFO (FWFT) and splits it into Y, U and V planes. It run-length encodes each plane and can optionally suppress runs that are identical to the previous row (delta mode). It emits fixed 5-byte packets over a valid/ready byte stream to the UART transmitter. Previous-row storage is an internal ping-pong bank, so no second FIFO is needed.

## Interface
- RowPixelWidth, 640, pixels per row; even, 2..4096.
- RunLimit, 256, maximum run length per packet; 1..256.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- i_pixel  in  16  FWFT head: [15:8] Y, [7:0] chroma (U on even pixel, V on odd).
- i_empty  in  1  capture FIFO empty.
- o_fetch  out  1  pop strobe; the head is consumed in the same cycle.
- i_frame_start  in  1  pulse: row counter to 0, previous row invalid.
- i_delta_en  in  1  suppress runs equal to the previous row.
- o_byte  out  8  packet byte.
- o_byte_valid  out  1  o_byte is valid.
- i_byte_ready  in  1  sink accepts; a transfer happens when valid && ready.
- o_row_done  out  1  one-cycle pulse after the last byte of a row.
- o_busy  out  1  high in SCAN/EMIT/DONE.

## Operation
- Reset values: o_fetch=0, o_byte=0, o_byte_valid=0, o_row_done=0, o_busy=0, row counter=0, bank select=0, prev_valid=0, state=LOAD.
- **LOAD**
  - Each cycle with !i_empty: o_fetch=1 and pixel p is written to the current bank.
    - Y[p] = i_pixel[15:8].
    - U[p/2] (p even) or V[p/2] (p odd) = i_pixel[7:0].
  - After pixel RowPixelWidth-1 is written, go to SCAN.
  - i_frame_start is honoured only in LOAD with p=0; it is ignored at all other times.
- **SCAN**
  - Planes are walked in order Y (RowPixelWidth elements), U, V (RowPixelWidth/2 each).
  - Per element: value v, changed flag c = !prev_valid || !i_delta_en || (v != previous-bank element).
  - The open run closes when the next element has a different v or c, when its length reaches RunLimit, or at plane end.
  - A closed run with c=1 goes to EMIT. A closed run with c=0 is dropped.
- **EMIT**
  - Send 5 bytes in order:
    1. start[7:0].
    2. row[7:0].
    3. v.
    4. len-1.
    5. {chan[1:0], 2'b00, start[11:8]}, with chan Y=0, U=1, V=2.
  - start is the element index within the plane.
  - Scanning stalls until the 5th byte transfers, then returns to SCAN, or to DONE after the last V run.
- **DONE**
  - Pulse o_row_done.
  - row counter += 1, wrapping mod 256.
  - Toggle bank select; the current bank becomes the previous bank.
  - Set prev_valid=1, then go to LOAD.
- A row with every run suppressed emits 0 bytes and still pulses o_row_done.
- i_delta_en is sampled once at SCAN entry and held for the row.

## Timing
- o_fetch is combinational from state and !i_empty; one pixel per cycle at most. Empty cycles stall LOAD with no side effects.
- Bank RAMs are synchronous-read; they may infer block RAM.
- SCAN consumes at most 2 cycles per element when not emitting.
- First packet byte is valid no later than 4 cycles after SCAN entry when the first run closes.
- While o_byte_valid && !i_byte_ready, o_byte must hold stable and valid must not drop.
- Back-to-back transfers with ready held high take 5 consecutive cycles per packet.
- o_row_done is asserted 1 cycle after the final transfer, or after the final element when nothing is emitted.
- Asynchronous reset at any point:
  - Outputs go to reset values immediately.
  - Any partial packet is discarded.
  - prev_valid=0, so the next row encodes in full.

## Test plan
- RowPixelWidth=8, RunLimit=4, delta off, 8 pixels of 16'h1080 -> 4 packets, 20 bytes:
  - 00 00 10 03 00
  - 04 00 10 03 00
  - 00 00 80 03 40
  - 00 00 80 03 80
  - then o_row_done.
- Same configuration, delta on, second identical row -> 0 bytes, o_row_done pulses, row counter 1 then 2.
- Delta on, second row differs only at pixel 5 with Y=0x20 -> exactly one packet 05 01 20 00 00.
- i_byte_ready held low 10 cycles after byte 2 -> o_byte stable at the row value through the stall, 20 bytes total, none duplicated or lost.
- Assert RST mid-EMIT, release, then feed an unchanged row with delta on -> o_byte_valid low during reset; full 20-byte emission follows because prev_valid was cleared.
- Toggle i_empty high on every other cycle during LOAD -> o_fetch only when !i_empty, and the encoded output is identical to the unstalled run.
